// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two-requester arbiter feeding a one-entry register-file write buffer.
// Ports: clock/reset (async, active-low); reqN_valid/reqN_ready/reqN_sel/reqN_data per requester;
// stall blocks the write port; op/reg_in_sel/reg_data_in/grant_id drive the register file from the slot.
// Macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority to requester 0.
package reg_write_arbiter_pkg;
  typedef enum logic [1:0] {REG_R0, REG_R1, REG_R2, REG_R3} register_sel_e;
  typedef enum logic {REG_NOP, REG_WRITE} registers_op_e;
endpackage

module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req0_valid,
  input  logic                      req1_valid,
  output logic                      req0_ready,
  output logic                      req1_ready,
  input  register_sel_e             req0_sel,
  input  register_sel_e             req1_sel,
  input  logic [DATA_BUS_WIDTH-1:0] req0_data,
  input  logic [DATA_BUS_WIDTH-1:0] req1_data,
  input  logic                      stall,
  output registers_op_e             op,
  output register_sel_e             reg_in_sel,
  output logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  output logic                      grant_id
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e                    state;
  register_sel_e             slot_sel;
  logic [DATA_BUS_WIDTH-1:0] slot_data;
  logic                      slot_id;
  logic                      drain, accept, gnt1, xfer;
`ifdef ARB_ROUND_ROBIN_EN
  logic prio;
  assign gnt1 = req1_valid && (!req0_valid || prio);
`else
  assign gnt1 = req1_valid && !req0_valid;
`endif
  assign drain = state == FULL && !stall;
  // reset gates accept so no ready is offered while reset is held
  assign accept = reset && (state == EMPTY || drain);
  assign req0_ready = accept && req0_valid && !gnt1;
  assign req1_ready = accept && gnt1;
  assign xfer = req0_ready || req1_ready;
  assign op = drain ? REG_WRITE : REG_NOP;
  assign reg_in_sel = slot_sel;
  assign reg_data_in = slot_data;
  assign grant_id = slot_id;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      slot_sel  <= REG_R0;
      slot_data <= '0;
      slot_id   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio      <= 1'b0;
`endif
    end else if (xfer) begin
      state     <= FULL;
      slot_sel  <= gnt1 ? req1_sel : req0_sel;
      slot_data <= gnt1 ? req1_data : req0_data;
      slot_id   <= gnt1;
`ifdef ARB_ROUND_ROBIN_EN
      prio      <= !gnt1;
`endif
    end else if (drain) begin
      state     <= EMPTY;
    end
  end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_BUS_WIDTH, default 8, setting the width of all data ports.
REQ-002 The block SHALL have the port clock, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the ports req0_valid (input, 1) and req1_valid (input, 1): requester i has a pending write.
REQ-005 The block SHALL have the ports req0_ready (output, 1) and req1_ready (output, 1): the write from requester i is accepted this cycle.
REQ-006 The block SHALL have the ports req0_sel and req1_sel, input, register_sel_e: the destination register of requester i.
REQ-007 The block SHALL have the ports req0_data and req1_data, input, DATA_BUS_WIDTH: the write data of requester i.
REQ-008 The block SHALL have the port stall, input, 1 bit: the register-file write port is unavailable this cycle.
REQ-009 The block SHALL have the port op, output, registers_op_e: REG_WRITE or REG_NOP, driven to the register file.
REQ-010 The block SHALL have the port reg_in_sel, output, register_sel_e: the write destination.
REQ-011 The block SHALL have the port reg_data_in, output, DATA_BUS_WIDTH: the write data.
REQ-012 The block SHALL have the port grant_id, output, 1 bit: the index of the requester that owns the buffered write.

Function
REQ-013 The block SHALL contain a one-entry write buffer (slot) holding valid, sel, data and id, with FSM states EMPTY (slot invalid) and FULL (slot valid).
REQ-014 A transfer SHALL occur on a rising edge where reqi_valid and reqi_ready are both high; a requester SHALL hold valid, sel and data stable until that edge.
REQ-015 A drain SHALL occur in any cycle with FULL and stall low; op SHALL be REG_WRITE exactly in drain cycles and REG_NOP otherwise.
REQ-016 accept SHALL equal (EMPTY or drain); at most one reqi_ready SHALL be high, and only when accept is high and that requester is granted.
REQ-017 FSM transitions: EMPTY with a transfer -> FULL; EMPTY without a transfer -> EMPTY; FULL with drain and transfer -> FULL (slot reloaded); FULL with drain and no transfer -> EMPTY; FULL with stall -> FULL (slot held).
REQ-018 reg_in_sel, reg_data_in and grant_id SHALL come directly from the slot registers, with no combinational path from the requester inputs.
REQ-019 Latency SHALL be one cycle: a transfer at edge N presents REG_WRITE in cycle N+1 when stall is low.
REQ-020 Throughput SHALL be one write per cycle with no bubbles while stall stays low.
REQ-021 If exactly one requester is valid, it SHALL be granted.
REQ-022 If both requesters are valid, the requester indicated by the priority pointer SHALL be granted.
REQ-023 After every transfer, the priority pointer SHALL point to the requester that was not granted.
REQ-024 The priority pointer SHALL change only on a transfer.
REQ-025 During stall, slot contents SHALL stay unchanged and the outputs SHALL hold their values with op at REG_NOP.
REQ-026 When both requesters target the same register, their writes SHALL be issued in grant order on separate cycles, with no merging or dropping.
REQ-027 An input stall SHALL never lose or duplicate a write.
REQ-028 Each accepted write SHALL be driven with REG_WRITE exactly once.

Reset
REQ-029 Asserting reset SHALL immediately, independent of clock, force: slot EMPTY, priority pointer to requester 0, reg_in_sel to register 0, reg_data_in to 0, grant_id to 0.
REQ-030 While reset is asserted, op SHALL be REG_NOP and both reqi_ready SHALL be low.
REQ-031 Reset asserted mid-operation SHALL discard any buffered write; that write SHALL not be issued after reset release.
REQ-032 The first transfer SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-033 With macro ARB_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-022 to REQ-024.
REQ-034 With ARB_ROUND_ROBIN_EN undefined, requester 0 SHALL always win simultaneous requests, and no priority pointer state SHALL exist.
REQ-035 All other behaviour SHALL be identical with and without ARB_ROUND_ROBIN_EN.

Verification
REQ-036 Scenario, single requester: req0 valid, sel=2, data=0x5A, stall=0 -> req0_ready=1 at the edge; next cycle op=REG_WRITE, reg_in_sel=2, reg_data_in=0x5A, grant_id=0.
REQ-037 Scenario, contention (round-robin): both requesters valid for 4 cycles -> grants 0,1,0,1, op=REG_WRITE on 4 consecutive cycles.
REQ-038 Scenario, contention (fixed priority): same stimulus with ARB_ROUND_ROBIN_EN undefined -> req0 granted every cycle and req1_ready stays 0.
REQ-039 Scenario, stall: slot FULL with data=0x33 and stall=1 for 3 cycles while req1 is valid -> op=REG_NOP and both readies=0 for 3 cycles; after stall drops, one REG_WRITE of 0x33, then req1's write.
REQ-040 Scenario, same target: req0 (sel=1, data=0x11) and req1 (sel=1, data=0x22) together from reset -> writes 0x11 then 0x22 on consecutive cycles.
REQ-041 Scenario, reset mid-operation: slot FULL with stall=1, reset pulsed low between clock edges -> outputs reset immediately, and no REG_WRITE after release until a new transfer.
